sram_ext_port_arbiter: RTL and testbench



---
 rtl/sram_ext_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_ext_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ext_port_arbiter.sv
// Round-robin arbiter sharing the external port of the data SRAM between
// the loader (requester 0) and the debug/dump unit (requester 1). A
// requester may hold the port for a bounded burst by asserting its lock bit.
module sram_ext_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int AW        = 64,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_wen,
    input  logic [1:0]        req_lock,
    input  logic [AW-1:0]     req_addr0,
    input  logic [AW-1:0]     req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } state_e;

    // One extra bit so the count can reach MAX_BURST (and stays legal when CNT_W is 0).
    localparam int BW = CNT_W + 1;
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              gnt_any;
    logic              gnt_idx;
    logic              lock_held;
    logic              sel_wen;
    logic              sel_lock;
    logic [BW-1:0]     cnt_base;
    logic [BW-1:0]     cnt_next;

    // Grant selection: a live lock wins outright, otherwise round-robin between valid requesters.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = 1'b0;
        lock_held = 1'b0;
        if (state_q == LOCKED0 && req_valid[0]) begin
            gnt_any   = 1'b1;
            gnt_idx   = 1'b0;
            lock_held = 1'b1;
        end else if (state_q == LOCKED1 && req_valid[1]) begin
            gnt_any   = 1'b1;
            gnt_idx   = 1'b1;
            lock_held = 1'b1;
        end else if (req_valid == 2'b11) begin
            gnt_any = 1'b1;
            gnt_idx = rr_ptr_q;
        end else if (req_valid[0]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b0;
        end else if (req_valid[1]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b1;
        end
        if (arst) begin
            gnt_any = 1'b0;
        end
    end

    // Port mux, read-response tagging and burst/lock bookkeeping for the granted transfer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        rsp_valid_d = 2'b00;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        req_ready   = 2'b00;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        sel_wen     = gnt_idx ? req_wen[1]  : req_wen[0];
        sel_lock    = gnt_idx ? req_lock[1] : req_lock[0];
        cnt_base    = lock_held ? burst_cnt_q : '0;
        cnt_next    = cnt_base + BURST_ONE;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            mem_addr    = gnt_idx ? req_addr1  : req_addr0;
            mem_wdata   = gnt_idx ? req_wdata1 : req_wdata0;
            mem_wen     = sel_wen;
            mem_ren     = ~sel_wen;
            mem_addr_d  = mem_addr;
            mem_wdata_d = mem_wdata;
            if (!sel_wen) begin
                rsp_valid_d[gnt_idx] = 1'b1;
            end
            if (sel_lock && (cnt_next < BURST_MAX)) begin
                state_d     = gnt_idx ? LOCKED1 : LOCKED0;
                burst_cnt_d = cnt_next;
            end else begin
                state_d     = UNLOCKED;
                burst_cnt_d = '0;
                rr_ptr_d    = ~gnt_idx;
            end
        end else if (state_q != UNLOCKED) begin
            state_d     = UNLOCKED;
            burst_cnt_d = '0;
        end
    end

    // State, pointer, burst counter, response tag and held port values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= UNLOCKED;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            rsp_valid_q <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_ext_port_arbiter.sv
// Bench for sram_ext_port_arbiter: two instances (MAX_BURST=8 and MAX_BURST=1)
// share the same stimulus, each backed by its own SRAM and its own reference model.
module tb_sram_ext_port_arbiter;

    localparam int DW   = 32;
    localparam int AWID = 64;

    logic clk = 1'b0;
    logic arst;
    logic [1:0]      req_valid, req_wen, req_lock;
    logic [AWID-1:0] req_addr0, req_addr1;
    logic [DW-1:0]   req_wdata0, req_wdata1;

    logic [1:0]      ready_a, rspv_a, ready_b, rspv_b;
    logic [DW-1:0]   rdata_a, rdata_b, wdata_a, wdata_b, mrd_a, mrd_b;
    logic [AWID-1:0] addr_a, addr_b;
    logic            wen_a, ren_a, wen_b, ren_b;

    logic [DW-1:0] sram_a [256];
    logic [DW-1:0] sram_b [256];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, indexed by instance.
    int            m_maxb [2] = '{8, 1};
    int            m_owner [2];
    int            m_used [2];
    int            m_prio [2];
    bit            m_pend_v [2];
    int            m_pend_k [2];
    logic [DW-1:0] m_pend_data [2];
    logic [AWID-1:0] m_last_addr [2];
    logic [DW-1:0] m_last_wd [2];
    logic [DW-1:0] m_mem [2][256];

    always #5 clk = ~clk;

    sram_ext_port_arbiter #(.DATA_W(DW), .AW(AWID), .MAX_BURST(8), .CNT_W(3)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(ready_a), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
        .mem_addr(addr_a), .mem_wen(wen_a), .mem_ren(ren_a), .mem_wdata(wdata_a),
        .mem_rdata(mrd_a)
    );

    sram_ext_port_arbiter #(.DATA_W(DW), .AW(AWID), .MAX_BURST(1), .CNT_W(0)) dut1 (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(ready_b), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
        .mem_addr(addr_b), .mem_wen(wen_b), .mem_ren(ren_b), .mem_wdata(wdata_b),
        .mem_rdata(mrd_b)
    );

    // Synchronous SRAMs: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        if (wen_a) sram_a[addr_a[9:2]] <= wdata_a;
        if (ren_a) mrd_a <= sram_a[addr_a[9:2]];
        if (wen_b) sram_b[addr_b[9:2]] <= wdata_b;
        if (ren_b) mrd_b <= sram_b[addr_b[9:2]];
    end

    // Preload both SRAMs and the model memories with the same contents.
    initial begin
        for (int j = 0; j < 256; j++) begin
            logic [DW-1:0] v;
            v = (j == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 ^ (32'(j) * 32'h0101_0101));
            sram_a[j] <= v;
            sram_b[j] <= v;
            m_mem[0][j] = v;
            m_mem[1][j] = v;
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] w,
                                 input logic [1:0] l, input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        arst       = r;
        req_valid  = v;
        req_wen    = w;
        req_lock   = l;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
    endtask

    // One model step per instance: predict this cycle's outputs, compare, then advance.
    task automatic modelStep(input int i);
        logic [1:0]      a_ready, a_rspv, e_ready;
        logic            a_wen, a_ren, e_wen;
        logic [AWID-1:0] a_addr, e_addr;
        logic [DW-1:0]   a_wd, a_rd, e_wd;
        int g, base, widx;
        if (i == 0) begin
            a_ready = ready_a; a_rspv = rspv_a; a_wen = wen_a; a_ren = ren_a;
            a_addr = addr_a; a_wd = wdata_a; a_rd = rdata_a;
        end else begin
            a_ready = ready_b; a_rspv = rspv_b; a_wen = wen_b; a_ren = ren_b;
            a_addr = addr_b; a_wd = wdata_b; a_rd = rdata_b;
        end
        if (arst) begin
            checkOutput("rst_ready", i, 64'(a_ready), 64'd0);
            checkOutput("rst_rspv", i, 64'(a_rspv), 64'd0);
            checkOutput("rst_wen", i, 64'(a_wen), 64'd0);
            checkOutput("rst_ren", i, 64'(a_ren), 64'd0);
            m_owner[i] = -1; m_used[i] = 0; m_prio[i] = 0; m_pend_v[i] = 0;
            m_last_addr[i] = '0; m_last_wd[i] = '0;
            return;
        end
        checkOutput("rsp_valid", i, 64'(a_rspv), m_pend_v[i] ? (64'd1 << m_pend_k[i]) : 64'd0);
        if (m_pend_v[i]) checkOutput("rsp_rdata", i, 64'(a_rd), 64'(m_pend_data[i]));
        m_pend_v[i] = 0;

        g = -1;
        base = 0;
        if (m_owner[i] >= 0) begin
            if (req_valid[m_owner[i]]) begin
                g = m_owner[i];
                base = m_used[i];
            end
        end
        if (g < 0) begin
            if (req_valid == 2'b11) g = m_prio[i];
            else if (req_valid[0]) g = 0;
            else if (req_valid[1]) g = 1;
        end

        if (g < 0) begin
            checkOutput("idle_ready", i, 64'(a_ready), 64'd0);
            checkOutput("idle_wen", i, 64'(a_wen), 64'd0);
            checkOutput("idle_ren", i, 64'(a_ren), 64'd0);
            checkOutput("idle_addr", i, a_addr, m_last_addr[i]);
            checkOutput("idle_wdata", i, 64'(a_wd), 64'(m_last_wd[i]));
            m_owner[i] = -1;
            m_used[i] = 0;
        end else begin
            e_ready = (g == 1) ? 2'b10 : 2'b01;
            e_addr  = (g == 1) ? req_addr1 : req_addr0;
            e_wd    = (g == 1) ? req_wdata1 : req_wdata0;
            e_wen   = req_wen[g];
            checkOutput("gnt_ready", i, 64'(a_ready), 64'(e_ready));
            checkOutput("gnt_wen", i, 64'(a_wen), 64'(e_wen));
            checkOutput("gnt_ren", i, 64'(a_ren), 64'(!e_wen));
            checkOutput("gnt_addr", i, a_addr, e_addr);
            checkOutput("gnt_wdata", i, 64'(a_wd), 64'(e_wd));
            m_last_addr[i] = e_addr;
            m_last_wd[i] = e_wd;
            widx = int'(e_addr[9:2]);
            if (e_wen) begin
                m_mem[i][widx] = e_wd;
            end else begin
                m_pend_v[i] = 1;
                m_pend_k[i] = g;
                m_pend_data[i] = m_mem[i][widx];
            end
            if (req_lock[g] && (base + 1 < m_maxb[i])) begin
                m_owner[i] = g;
                m_used[i] = base + 1;
            end else begin
                m_owner[i] = -1;
                m_used[i] = 0;
                m_prio[i] = 1 - g;
            end
        end
    endtask

    // Compare process: checks both instances against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) modelStep(i);
        end
    end

    // Directed scenarios with literal expectations, then a randomized run.
    initial begin
        logic [1:0] v, w, l;
        logic       r;
        arst = 1'b1; req_valid = '0; req_wen = '0; req_lock = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        // Single read of preloaded word.
        applyStimulus(0, 2'b01, 2'b00, 2'b00, 64'h10, 64'h0, 0, 0);
        @(negedge clk);
        checkOutput("lit_rd_ready", 0, 64'(ready_a), 64'h1);
        checkOutput("lit_rd_ren", 0, 64'(ren_a), 64'h1);
        checkOutput("lit_rd_addr", 0, addr_a, 64'h10);
        applyStimulus(0, 2'b00, 2'b00, 2'b00, 64'h10, 64'h0, 0, 0);
        @(negedge clk);
        checkOutput("lit_rsp_valid", 0, 64'(rspv_a), 64'h1);
        checkOutput("lit_rsp_data", 0, 64'(rdata_a), 64'hDEAD_BEEF);
        applyStimulus(0, 2'b00, 2'b00, 2'b00, 64'h10, 64'h0, 0, 0);
        @(negedge clk);
        checkOutput("lit_idle_wen", 0, 64'(wen_a), 64'h0);
        checkOutput("lit_idle_ren", 0, 64'(ren_a), 64'h0);
        checkOutput("lit_idle_rspv", 0, 64'(rspv_a), 64'h0);

        // Alternating writes, then read-back.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 2'b11, 2'b11, 2'b00, 64'h0, 64'h4, 32'h1111_1111, 32'h2222_2222);
            @(negedge clk);
            checkOutput("lit_alt_ready", 0, 64'(ready_a), (c % 2 == 0) ? 64'h1 : 64'h2);
        end
        applyStimulus(0, 2'b01, 2'b00, 2'b00, 64'h0, 64'h4, 0, 0);
        @(negedge clk);
        checkOutput("lit_rb0_ready", 0, 64'(ready_a), 64'h1);
        applyStimulus(0, 2'b10, 2'b00, 2'b00, 64'h0, 64'h4, 0, 0);
        @(negedge clk);
        checkOutput("lit_rb0_rspv", 0, 64'(rspv_a), 64'h1);
        checkOutput("lit_rb0_data", 0, 64'(rdata_a), 64'h1111_1111);
        applyStimulus(0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h4, 0, 0);
        @(negedge clk);
        checkOutput("lit_rb1_rspv", 0, 64'(rspv_a), 64'h2);
        checkOutput("lit_rb1_data", 0, 64'(rdata_a), 64'h2222_2222);

        // Locked burst by req0 against a waiting req1.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 2'b11, 2'b11, 2'b01, 64'h40 + 64'(c * 4), 64'h80, 32'(c), 32'hBB);
            @(negedge clk);
            checkOutput("lit_burst_ready", 0, 64'(ready_a), (c == 8) ? 64'h2 : 64'h1);
            checkOutput("lit_mb1_ready", 1, 64'(ready_b), (c % 2 == 0) ? 64'h1 : 64'h2);
        end

        // req1 lock dropped by valid while req0 waits.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 2'b10, 2'b11, 2'b10, 64'h0, 64'h20, 0, 32'h33);
            @(negedge clk);
            checkOutput("lit_lk1_ready", 0, 64'(ready_a), 64'h2);
        end
        applyStimulus(0, 2'b01, 2'b11, 2'b00, 64'h24, 64'h20, 32'h44, 32'h33);
        @(negedge clk);
        checkOutput("lit_drop_ready", 0, 64'(ready_a), 64'h1);
        applyStimulus(0, 2'b11, 2'b11, 2'b00, 64'h24, 64'h20, 32'h44, 32'h33);
        @(negedge clk);
        checkOutput("lit_after_drop", 0, 64'(ready_a), 64'h2);

        // Reset with a req1 read in flight.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b10, 2'b00, 2'b00, 64'h0, 64'h10, 0, 0);
        @(negedge clk);
        checkOutput("lit_rr1_ready", 0, 64'(ready_a), 64'h2);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 2'b11, 2'b00, 2'b00, 64'h0, 64'h10, 0, 0);
            @(negedge clk);
            checkOutput("lit_rst_rspv", 0, 64'(rspv_a), 64'h0);
            checkOutput("lit_rst_ready", 0, 64'(ready_a), 64'h0);
        end
        applyStimulus(0, 2'b11, 2'b11, 2'b00, 64'h30, 64'h34, 32'h55, 32'h66);
        @(negedge clk);
        checkOutput("lit_post_rst", 0, 64'(ready_a), 64'h1);

        // Both requesters locking.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 2'b11, 2'b11, 2'b11, 64'h50, 64'h54, 32'(c), 32'(c + 100));
            @(negedge clk);
            checkOutput("lit_bothlk_a", 0, 64'(ready_a), 64'h1);
            checkOutput("lit_bothlk_b", 1, 64'(ready_b), (c % 2 == 0) ? 64'h1 : 64'h2);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 5) ? 2'b11 : 2'($urandom);
            w = 2'($urandom);
            l[0] = ($urandom_range(0, 3) != 0);
            l[1] = ($urandom_range(0, 3) != 0);
            applyStimulus(r, v, w, l,
                          64'($urandom_range(0, 15)) << 2, 64'($urandom_range(0, 15)) << 2,
                          $urandom, $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
